// File: rtl/snn_pkg.sv
// Shared constants and types for the spike-index interface.
// The packer and the weight-lookup stage both import this package so that
// both ends agree on the list format.
package snn_pkg;

  // Capacity of the index list per timestep. It must stay <= 255 so that
  // the count fits in CNT_W bits.
  localparam int MAX_SPIKE = 128;
  // Width of one synapse index.
  localparam int IDX_W     = 14;
  // Number of legal synapse indices (0 .. N_SYNAPSE-1).
  localparam int N_SYNAPSE = 10000;
  // Width of the spike count.
  localparam int CNT_W     = 8;

  typedef logic [IDX_W-1:0] spike_idx_t;
  typedef logic [CNT_W-1:0] spike_cnt_t;

  // Drop reasons for one frame. Each flag is set once and stays set until
  // the frame closes.
  typedef struct packed {
    logic ovf;   // a legal index was dropped because the list was full
    logic rerr;  // an index >= N_SYNAPSE was dropped
  } frame_flags_t;

  // Returns 1 when idx names a real synapse. The compare is widened to
  // 32 bits so that it stays correct if N_SYNAPSE ever reaches 2**IDX_W.
  function automatic logic idx_in_range(input spike_idx_t idx);
    return 32'(idx) < 32'(N_SYNAPSE);
  endfunction

endpackage

// File: rtl/spike_index_packer.sv
// Collects serial spike indices during a timestep and emits them as a
// flat list, with a count and a one-cycle valid pulse, on frame_end.
// A working buffer fills while the output hold register presents the
// previous frame, so collection never stalls.
module spike_index_packer
  import snn_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       spike_valid,
  input  logic [IDX_W-1:0]           spike_index,
  input  logic                       frame_end,
  output logic [IDX_W*MAX_SPIKE-1:0] index_flat,
  output logic [CNT_W-1:0]           num_spike_out,
  output logic                       valid_out,
  output logic                       overflow_out,
  output logic                       range_err_out,
  output logic [15:0]                frame_id
);

  localparam spike_cnt_t MAX_CNT = spike_cnt_t'(MAX_SPIKE);

  // Working buffer invariant: every entry at or above wcnt is zero.
  // Reset and emit both clear the whole buffer, and a slot is written only
  // at position wcnt. Because of this the emitted list needs no masking of
  // stale entries from an earlier frame.
  spike_idx_t [MAX_SPIKE-1:0] wbuf;
  spike_idx_t [MAX_SPIKE-1:0] wbuf_nxt;
  spike_cnt_t                 wcnt;
  spike_cnt_t                 wcnt_nxt;
  frame_flags_t               flags;
  frame_flags_t               flags_nxt;

  logic in_range;
  logic has_room;
  logic accept;

  // Classify this cycle's event and form the post-event working state.
  // The emit path also uses this state, so a spike that arrives together
  // with frame_end is counted in the closing frame.
  always_comb begin
    in_range      = idx_in_range(spike_index);
    has_room      = (wcnt < MAX_CNT);
    accept        = spike_valid && in_range && has_room;
    wcnt_nxt      = wcnt + spike_cnt_t'(accept);
    flags_nxt     = flags;
    if (spike_valid && !in_range)
      flags_nxt.rerr = 1'b1;
    if (spike_valid && in_range && !has_room)
      flags_nxt.ovf = 1'b1;
  end

  // Slot k loads the incoming index only when it is the next free slot.
  for (genvar k = 0; k < MAX_SPIKE; k++) begin : g_entry
    assign wbuf_nxt[k] = (accept && (wcnt == spike_cnt_t'(k))) ? spike_index : wbuf[k];
  end

  // Working state. frame_end starts a fresh, zeroed frame. A spike in the
  // next cycle goes to slot 0, so there is no dead cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf  <= '0;
      wcnt  <= '0;
      flags <= '0;
    end else if (frame_end) begin
      wbuf  <= '0;
      wcnt  <= '0;
      flags <= '0;
    end else begin
      wbuf  <= wbuf_nxt;
      wcnt  <= wcnt_nxt;
      flags <= flags_nxt;
    end
  end

  // Output hold register. It changes only on an emit, because the
  // downstream lookup reads index_flat combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_flat    <= '0;
      num_spike_out <= '0;
      overflow_out  <= 1'b0;
      range_err_out <= 1'b0;
      frame_id      <= '0;
    end else if (frame_end) begin
      index_flat    <= wbuf_nxt;
      num_spike_out <= wcnt_nxt;
      overflow_out  <= flags_nxt.ovf;
      range_err_out <= flags_nxt.rerr;
      frame_id      <= frame_id + 16'd1;
    end
  end

  // One-cycle valid pulse, one cycle after frame_end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_out <= 1'b0;
    else     valid_out <= frame_end;
  end

endmodule
